// File: rtl/m2_generator_pkg.sv
// Shared definitions for the M2 clock generator: state encoding and default timing.
package m2_generator_pkg;

  // Default M2 timing in master_clock cycles
  localparam int unsigned M2_PERIOD_DEF = 24;
  localparam int unsigned M2_HIGH_DEF   = 15;

  // Width of the M2 rising-edge counter
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2
  } m2_state_e;

endpackage

// File: rtl/m2_generator.sv
// M2 clock generator: produces a registered M2 clock of M2_PERIOD cycles with
// M2_HIGH cycles high, started/stopped by m2_run at whole-period boundaries.
// Ports:
//   master_clock - clock, all state updates on its rising edge
//   nreset       - asynchronous active-low reset
//   m2_run       - 1 requests free-running M2, 0 requests stop at end of period
//   count_clear  - synchronous clear of m2_count (wins over increment)
//   m2           - registered M2 clock
//   m2_rise      - one-cycle pulse in the first high cycle of M2
//   m2_fall      - one-cycle pulse in the first low cycle after a high phase
//   m2_stopped   - high while the generator is stopped
//   m2_count     - number of M2 rising edges since reset or clear (wraps)
module m2_generator
  import m2_generator_pkg::*;
#(
  parameter int unsigned M2_PERIOD = M2_PERIOD_DEF,
  parameter int unsigned M2_HIGH   = M2_HIGH_DEF
) (
  input  logic               master_clock,
  input  logic               nreset,
  input  logic               m2_run,
  input  logic               count_clear,
  output logic               m2,
  output logic               m2_rise,
  output logic               m2_fall,
  output logic               m2_stopped,
  output logic [COUNT_W-1:0] m2_count
);

  localparam int unsigned PHASE_W = (M2_PERIOD > 1) ? $clog2(M2_PERIOD) : 1;
  localparam logic [PHASE_W-1:0] HIGH_LAST   = PHASE_W'(M2_HIGH - 1);
  localparam logic [PHASE_W-1:0] PERIOD_LAST = PHASE_W'(M2_PERIOD - 1);

  // Reject timing that would give no high phase or no low phase
  if ((M2_HIGH < 1) || (M2_PERIOD < M2_HIGH + 1)) begin : g_param_check
    $error("m2_generator: need M2_HIGH >= 1 and M2_PERIOD >= M2_HIGH + 1");
  end

  m2_state_e            state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 rise_d, fall_d;
  logic [COUNT_W-1:0]   count_d;

  // Next-state, phase and edge-pulse logic; phase runs 0..M2_PERIOD-1 across HIGH and LOW
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STOPPED: begin
        if (m2_run) begin
          state_d = HIGH;
          phase_d = '0;
          rise_d  = 1'b1;
        end
      end
      HIGH: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_q == HIGH_LAST) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end
      end
      LOW: begin
        if (phase_q == PERIOD_LAST) begin
          // m2_run is only honoured here so a period is never cut short
          phase_d = '0;
          if (m2_run) begin
            state_d = HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = STOPPED;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      default: begin
        state_d = STOPPED;
        phase_d = '0;
      end
    endcase
  end

  // Rising-edge counter; clear takes priority over a coincident rise
  always_comb begin
    count_d = m2_count;
    if (count_clear) begin
      count_d = '0;
    end else if (rise_d) begin
      count_d = m2_count + COUNT_W'(1);
    end
  end

  // State register and registered outputs, all derived from next-state values
  always_ff @(posedge master_clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= STOPPED;
      phase_q    <= '0;
      m2         <= 1'b0;
      m2_rise    <= 1'b0;
      m2_fall    <= 1'b0;
      m2_stopped <= 1'b1;
      m2_count   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      m2         <= (state_d == HIGH);
      m2_rise    <= rise_d;
      m2_fall    <= fall_d;
      m2_stopped <= (state_d == STOPPED);
      m2_count   <= count_d;
    end
  end

endmodule
